// File: rtl/nn_pkg.sv
// Shared types and helpers for the polar burst neuron node: FSM state
// encoding, popcount width and accumulator saturation.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        REFRACT = 2'd2
    } burst_state_e;

    // Width that holds a popcount of n synapses plus bias and offset, with one spare sign bit.
    function automatic int pop_w(input int n);
        return $clog2(n + 3) + 1;
    endfunction

    // Clamp v into the symmetric range [-lim, +lim].
    function automatic int sat_int(input int v, input int lim);
        if (v > lim) begin
            return lim;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/nn_node_polar_burst_if.sv
// Signal bundle between a layer input bus and the polar burst node.
// Optional macro NN_NODE_SATCNT_EN adds the sat_cnt status output.
interface nn_node_polar_burst_if #(
    parameter int N = 4
);
    logic [N-1:0] a;
    logic [N-1:0] alpha;
    logic [N-1:0] SIGN_alpha;
    logic         beta;
    logic         SIGN_beta;
    logic         d;
    logic         z;
    logic         a_out;
    logic         busy;
`ifdef NN_NODE_SATCNT_EN
    logic [7:0]   sat_cnt;

    modport master (
        output a, alpha, SIGN_alpha, beta, SIGN_beta, d,
        input  z, a_out, busy, sat_cnt
    );
    modport slave (
        input  a, alpha, SIGN_alpha, beta, SIGN_beta, d,
        output z, a_out, busy, sat_cnt
    );
`else
    modport master (
        output a, alpha, SIGN_alpha, beta, SIGN_beta, d,
        input  z, a_out, busy
    );
    modport slave (
        input  a, alpha, SIGN_alpha, beta, SIGN_beta, d,
        output z, a_out, busy
    );
`endif
endinterface

// File: rtl/nn_burst_gate.sv
// Burst-gated transfer stage: watches the z stream and emits a fixed-length
// a_out pulse followed by a refractory period once enough ones accumulate.
//
// state   | meaning
// IDLE    | shifting z into history, waiting for BURST_THRESH ones
// BURST   | a_out high, counting down PULSE_DUR cycles
// REFRACT | a_out low, counting down REFRACT_DUR cycles before re-arming
module nn_burst_gate
    import nn_pkg::*;
#(
    parameter int MEMSIZE      = 6,
    parameter int BURST_THRESH = 4,
    parameter int PULSE_DUR    = 80,
    parameter int REFRACT_DUR  = 10,
    parameter int CNT_W        = 8
) (
    input  logic CLK,
    input  logic INIT,
    input  logic z_in,
    output logic a_out,
    output logic busy
);

    localparam logic [CNT_W-1:0] PLOAD = CNT_W'(PULSE_DUR - 1);
    localparam logic [CNT_W-1:0] RLOAD = (REFRACT_DUR > 0) ? CNT_W'(REFRACT_DUR - 1) : '0;

    burst_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MEMSIZE-1:0] hist_q, hist_d, hist_upd;
    logic               a_out_q, a_out_d;
    logic               busy_q, busy_d;

    // State register: FSM, counter, history and registered outputs.
    always_ff @(posedge CLK) begin
        if (!INIT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hist_q  <= '0;
            a_out_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            a_out_q <= a_out_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; history only moves while idle and is emptied on every burst.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hist_d   = '0;
        hist_upd = (hist_q << 1) | MEMSIZE'(z_in);
        case (state_q)
            IDLE: begin
                if ($countones(hist_upd) >= BURST_THRESH) begin
                    state_d = BURST;
                    cnt_d   = PLOAD;
                end else begin
                    hist_d = hist_upd;
                end
            end
            BURST: begin
                if (cnt_q == '0) begin
                    if (REFRACT_DUR > 0) begin
                        state_d = REFRACT;
                        cnt_d   = RLOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REFRACT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so a_out rises on the firing edge.
    always_comb begin
        a_out_d = (state_d == BURST);
        busy_d  = (state_d != IDLE);
    end

    assign a_out = a_out_q;
    assign busy  = busy_q;

endmodule

// File: rtl/nn_node_polar_burst.sv
// Polar stochastic neuron node: saturating signed difference accumulator
// producing z, feeding a burst gate that produces a_out/busy.
// Optional macro NN_NODE_SATCNT_EN adds an 8-bit count of clamp cycles.
module nn_node_polar_burst
    import nn_pkg::*;
#(
    parameter int N            = 4,
    parameter int ACC_W        = 4,
    parameter int MEMSIZE      = 6,
    parameter int BURST_THRESH = 4,
    parameter int PULSE_DUR    = 80,
    parameter int REFRACT_DUR  = 10,
    parameter int CNT_W        = 8
) (
    input  logic                   CLK,
    input  logic                   INIT,
    nn_node_polar_burst_if.slave   bus
);

    localparam int PW  = pop_w(N);
    localparam int SW  = ACC_W + 2;
    localparam int LIM = 2 ** (ACC_W - 1) - 1;

    logic [PW-1:0]           pos_c, neg_c;
    logic signed [SW-1:0]    nxt, adj;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    z_q, z_d;
    int                      adj_i;
    logic                    a_out_w, busy_w;

    // Accumulate signed products, emit one z per unit above zero, then clamp.
    always_comb begin
        pos_c = PW'(bus.beta & ~bus.SIGN_beta);
        neg_c = PW'(bus.beta & bus.SIGN_beta) + PW'(bus.d);
        for (int i = 0; i < N; i++) begin
            pos_c = pos_c + PW'(bus.a[i] & bus.alpha[i] & ~bus.SIGN_alpha[i]);
            neg_c = neg_c + PW'(bus.a[i] & bus.alpha[i] & bus.SIGN_alpha[i]);
        end
        nxt   = SW'(acc_q) + SW'($signed({1'b0, pos_c})) - SW'($signed({1'b0, neg_c}));
        z_d   = !nxt[SW-1] && (nxt != '0);
        adj   = z_d ? (nxt - SW'(1)) : nxt;
        adj_i = int'(adj);
        acc_d = ACC_W'(sat_int(adj_i, LIM));
    end

    // Accumulator and z register.
    always_ff @(posedge CLK) begin
        if (!INIT) begin
            acc_q <= '0;
            z_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
        end
    end

    nn_burst_gate #(
        .MEMSIZE      (MEMSIZE),
        .BURST_THRESH (BURST_THRESH),
        .PULSE_DUR    (PULSE_DUR),
        .REFRACT_DUR  (REFRACT_DUR),
        .CNT_W        (CNT_W)
    ) u_gate (
        .CLK   (CLK),
        .INIT  (INIT),
        .z_in  (z_d),
        .a_out (a_out_w),
        .busy  (busy_w)
    );

    assign bus.z     = z_q;
    assign bus.a_out = a_out_w;
    assign bus.busy  = busy_w;

`ifdef NN_NODE_SATCNT_EN
    logic       clamp;
    logic [7:0] sat_cnt_q, sat_cnt_d;

    // Count cycles where the accumulator hit a rail, sticking at 255.
    always_comb begin
        clamp     = (adj_i > LIM) || (adj_i < -LIM);
        sat_cnt_d = (clamp && (sat_cnt_q != 8'hFF)) ? (sat_cnt_q + 8'd1) : sat_cnt_q;
    end

    // Saturation counter register.
    always_ff @(posedge CLK) begin
        if (!INIT) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign bus.sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_nn_node_polar_burst.sv
// Bench for nn_node_polar_burst: directed scenarios plus random traffic,
// checked every cycle against a timeline model of the node.
module tb_nn_node_polar_burst;

    localparam int N       = 4;
    localparam int ACC_W   = 4;
    localparam int MEMSIZE = 6;
    localparam int THRESH  = 4;
    localparam int P       = 80;
    localparam int R       = 10;
    localparam int L       = 2 ** (ACC_W - 1) - 1;

    logic CLK = 1'b0;
    logic INIT;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    nn_node_polar_burst_if #(.N(N)) bus ();

    nn_node_polar_burst #(
        .N            (N),
        .ACC_W        (ACC_W),
        .MEMSIZE      (MEMSIZE),
        .BURST_THRESH (THRESH),
        .PULSE_DUR    (P),
        .REFRACT_DUR  (R),
        .CNT_W        (8)
    ) dut (
        .CLK  (CLK),
        .INIT (INIT),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Model: value of acc, z, and a burst timeline. m_span counts the edges
    // still owed to the current burst (pulse, refractory, then one settle edge).
    int m_acc  = 0;
    bit m_z    = 0;
    bit m_aout = 0;
    bit m_busy = 0;
    int m_span = 0;
    bit m_hist[$];

    always @(posedge CLK) begin
        int pos, neg, s, ones;
        if (!INIT) begin
            m_acc = 0; m_z = 0; m_aout = 0; m_busy = 0; m_span = 0;
            m_hist.delete();
        end else begin
            pos = 0; neg = 0;
            for (int i = 0; i < N; i++) begin
                if (bus.a[i] && bus.alpha[i]) begin
                    if (bus.SIGN_alpha[i]) neg++; else pos++;
                end
            end
            if (bus.beta) begin
                if (bus.SIGN_beta) neg++; else pos++;
            end
            if (bus.d) neg++;
            s   = m_acc + pos - neg;
            m_z = (s >= 1);
            if (m_z) s = s - 1;
            if (s > L) s = L;
            if (s < -L) s = -L;
            m_acc = s;
            if (m_span > 0) begin
                m_busy = (m_span >= 2);
                m_aout = (m_span >= R + 2);
                m_span--;
            end else begin
                m_hist.push_front(m_z);
                if (m_hist.size() > MEMSIZE) void'(m_hist.pop_back());
                ones = 0;
                foreach (m_hist[k]) ones += m_hist[k];
                if (ones >= THRESH) begin
                    m_aout = 1; m_busy = 1; m_span = P + R;
                    m_hist.delete();
                end else begin
                    m_aout = 0; m_busy = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("z", {31'd0, bus.z}, {31'd0, m_z});
            chk("a_out", {31'd0, bus.a_out}, {31'd0, m_aout});
            chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        end
    end

    task automatic set_in(input logic [N-1:0] a, input logic [N-1:0] al, input logic [N-1:0] sa,
                          input logic b, input logic sb, input logic dd);
        bus.a = a; bus.alpha = al; bus.SIGN_alpha = sa;
        bus.beta = b; bus.SIGN_beta = sb; bus.d = dd;
    endtask

    task automatic do_reset();
        INIT = 1'b0;
        @(negedge CLK);
        INIT = 1'b1;
    endtask

    // Count negedges until a_out equals lvl, giving up after maxc.
    task automatic run_until(input logic lvl, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.a_out !== lvl && n < maxc);
    endtask

    initial begin
        int n, zc, ac;
        INIT = 1'b0;
        set_in('0, '0, '0, 0, 0, 0);
        chk_en = 1'b1;

        // Reset held with random inputs.
        repeat (3) begin
            set_in(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge CLK);
            chk("rst_z", {31'd0, bus.z}, 0);
            chk("rst_busy", {31'd0, bus.busy}, 0);
        end

        // Single positive synapse: fire timing, pulse width, gap.
        set_in(4'b0001, 4'b0001, 4'b0000, 0, 0, 0);
        do_reset();
        run_until(1'b1, 20, n);   chk("first_fire", n, 4);
        run_until(1'b0, 200, n);  chk("pulse_len", n, P);
        run_until(1'b1, 200, n);  chk("gap_len", n, R + THRESH);
        chk("acc_hold", m_acc, 0);

        // Reset at burst cycle 30.
        repeat (29) @(negedge CLK);
        INIT = 1'b0;
        @(negedge CLK);
        chk("midrst_aout", {31'd0, bus.a_out}, 0);
        chk("midrst_busy", {31'd0, bus.busy}, 0);
        INIT = 1'b1;
        run_until(1'b1, 20, n);   chk("refire_after_rst", n, 4);

        // Balanced positive and negative synapse.
        set_in(4'b0011, 4'b0011, 4'b0010, 0, 0, 0);
        do_reset();
        ac = 0; zc = 0;
        repeat (40) begin
            @(negedge CLK);
            ac += bus.a_out; zc += bus.z;
        end
        chk("bal_aout_ones", ac, 0);
        chk("bal_z_ones", zc, 0);

        // +5 per cycle then -5 per cycle: rail clamping.
        set_in(4'b1111, 4'b1111, 4'b0000, 1, 0, 0);
        do_reset();
        @(negedge CLK); chk("acc_step1", m_acc, 4);
        @(negedge CLK); chk("acc_step2", m_acc, 7);
        repeat (3) @(negedge CLK);
        chk("acc_pos_rail", m_acc, 7);
        set_in(4'b1111, 4'b1111, 4'b1111, 1, 1, 0);
        repeat (6) @(negedge CLK);
        chk("acc_neg_rail", m_acc, -7);
        chk("neg_z", {31'd0, bus.z}, 0);

        // Offset cancels the single positive input.
        set_in(4'b0001, 4'b0001, 4'b0000, 0, 0, 1);
        do_reset();
        zc = 0;
        repeat (20) begin
            @(negedge CLK);
            zc += bus.z;
        end
        chk("offset_z_ones", zc, 0);

        // Random traffic with occasional resets.
        repeat (3000) begin
            set_in(4'($urandom), 4'($urandom | $urandom), 4'($urandom & $urandom & $urandom),
                   1'($urandom), ($urandom_range(3) == 0), ($urandom_range(3) == 0));
            INIT = ($urandom_range(199) != 0);
            @(negedge CLK);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_node_polar_burst.md
Name: nn_node_polar_burst

Overview:
- Parametrised successor to the stochastic polar neuron node. It sums N signed stochastic input×weight products plus a signed bias in a saturating difference accumulator.
- It applies an offset stream d and emits a unipolar stochastic activation z.
- z drives a burst-gated transfer FSM whose window, threshold, pulse and refractory lengths are all parameters rather than fixed constants.
- Sits between layer input buses and the next layer's a inputs in the generated network.

Parameters:
- N, 4, number of synaptic inputs (≥1)
- ACC_W, 4, accumulator width, signed two's complement (≥3)
- MEMSIZE, 6, burst-detect history window in cycles (≥1)
- BURST_THRESH, 4, ones in window required to fire a burst (1..MEMSIZE)
- PULSE_DUR, 80, a_out high duration in cycles (≥1)
- REFRACT_DUR, 10, refractory cycles after burst (≥0)
- CNT_W, 8, burst/refractory counter width; must hold max(PULSE_DUR, REFRACT_DUR)

Ports:
- CLK input 1 clock, all logic rising-edge
- INIT input 1 reset, synchronous, active-low
- a input N stochastic activation bits
- alpha input N stochastic weight magnitude bits
- SIGN_alpha input N weight signs (1 = negative)
- beta input 1 bias magnitude bit
- SIGN_beta input 1 bias sign (1 = negative)
- d input 1 offset stream; each 1 subtracts one from the accumulator
- z output 1 registered stochastic pre-activation
- a_out output 1 registered burst-gated activation
- busy output 1 high in BURST or REFRACT

Behaviour:
- Reset (INIT=0 at a clock edge): acc=0, z=0, a_out=0, busy=0, history=0, counter=0, state=IDLE. Reset wins over all other events, including mid-burst.
- Per cycle, combinationally:
  - pos = popcount(a & alpha & ~SIGN_alpha) + (beta & ~SIGN_beta)
  - neg = popcount(a & alpha & SIGN_alpha) + (beta & SIGN_beta) + d
  - Both are computed at width clog2(N+3)+1 and sign-extended into a signed sum of width ACC_W+2 (no intermediate overflow).
  - nxt = acc + pos − neg
- Accumulator update:
  - If nxt ≥ 1: z ← 1, acc ← sat(nxt − 1).
  - Else: z ← 0, acc ← sat(nxt).
  - sat clamps to [−L, +L], where L = 2^(ACC_W−1) − 1.
  - Latency: inputs to z is one cycle.
  - Runs every cycle regardless of FSM state.
- History register: shift register of the last MEMSIZE z values. Newest bit = z_next.
- FSM states:
  - IDLE (a_out=0):
    - Shift z_next into history.
    - If popcount(updated history) ≥ BURST_THRESH: go to BURST, cnt ← PULSE_DUR−1, a_out ← 1 on the same edge.
  - BURST (a_out=1):
    - If cnt=0 and REFRACT_DUR>0: go to REFRACT, cnt ← REFRACT_DUR−1, a_out ← 0.
    - If cnt=0 and REFRACT_DUR=0: go to IDLE.
    - Else cnt ← cnt−1.
    - History held at 0.
  - REFRACT (a_out=0): if cnt=0, go to IDLE; else cnt ← cnt−1. History held at 0.
- a_out is high for exactly PULSE_DUR cycles per burst.
- Minimum gap between bursts is REFRACT_DUR + BURST_THRESH cycles.
- busy = (state ≠ IDLE), registered.

Optional Feature:
- Macro NN_NODE_SATCNT_EN.
- When defined:
  - Adds output sat_cnt [7:0].
  - Counts cycles in which sat clamped acc (either rail).
  - Saturates at 255; cleared by reset.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package nn_pkg:
  - FSM state enum (IDLE, BURST, REFRACT)
  - clog2-based popcount width function
  - saturation helper function
- One sub-module, nn_burst_gate: history, FSM and counter, taking z and producing a_out/busy.
- The accumulator stays in the top.

Test Plan:
1. Hold INIT=0 for 3 cycles with random inputs → z=0, a_out=0, busy=0 throughout.
2. N=4, a=alpha=4'b0001, SIGN_alpha=0, beta=0, d=0 → z=1 from cycle 1 every cycle, acc stays 0. a_out rises on cycle 4 (4th one, THRESH=4), stays high 80 cycles, low 10 cycles, then re-fires 4 cycles later.
3. a=alpha=4'b0011, SIGN_alpha=4'b0010 (one +, one −) → pos=neg, z stays 0, a_out never rises.
4. ACC_W=4, a=alpha=4'b1111, SIGN_alpha=0, beta=1, SIGN_beta=0 (+5/cycle) → acc steps 4, 7(clamp), 7… with z=1 each cycle. Then all inputs negative (−5/cycle) → acc reaches −7 and holds, z=0.
5. d=1, pos=1 every cycle → nxt=acc, z stays 0. Confirms offset cancels the single positive input.
6. INIT=0 asserted at cycle 30 of a burst → next cycle a_out=0, state IDLE, history cleared. With NN_NODE_SATCNT_EN, sat_cnt=0 after reset and counts clamp cycles in scenario 4.
